// File: rtl/clink_pkg.sv
// Shared Camera Link types: framer states, the per-clock Camera Link word,
// the clock-lane pattern and the 28-bit slot map onto four 7-bit lane words.
package clink_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        V_GAP   = 2'd1,
        LINE_ON = 2'd2,
        H_GAP   = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic       fval;
        logic       lval;
        logic       dval;
    } clink_word_t;

    typedef logic [3:0][6:0] lane_words_t;

    // Clock lane: high for slots 0,1 and 5,6 of every pixel clock.
    localparam logic [6:0] CLK_PATTERN = 7'b1100011;

    // Bit 6 of each lane word is slot 0, the first bit on the wire.
    function automatic lane_words_t map_slots(input clink_word_t w);
        lane_words_t l;
        l[0] = {w.b[0], w.a[5:0]};
        l[1] = {w.c[1:0], w.b[5:1]};
        l[2] = {w.dval, w.fval, w.lval, w.c[5:2]};
        l[3] = {1'b0, w.c[7:6], w.b[7:6], w.a[7:6]};
        return l;
    endfunction

endpackage

// File: rtl/clink_slot_mapper.sv
// Combinational Camera Link slot mapping; the receive-side checks reuse it
// to confirm their inverse mapping.
module clink_slot_mapper
    import clink_pkg::*;
(
    input  clink_word_t word,
    output logic [6:0]  lane_0,
    output logic [6:0]  lane_1,
    output logic [6:0]  lane_2,
    output logic [6:0]  lane_3
);

    lane_words_t lanes;

    assign lanes  = map_slots(word);
    assign lane_0 = lanes[0];
    assign lane_1 = lanes[1];
    assign lane_2 = lanes[2];
    assign lane_3 = lanes[3];

endmodule

// File: rtl/clink_base_tx_framer.sv
// Camera Link Base transmit framer: turns an AXI-Stream pixel stream into
// FVAL/LVAL/DVAL timing plus four 7-bit lane words and a clock-lane word
// per pixel clock, ready for a 7:1 serializer.
module clink_base_tx_framer
    import clink_pkg::*;
#(
    parameter int H_ACTIVE = 16,
    parameter int V_ACTIVE = 16,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 256,
    parameter int CNT_W    = 16
) (
    input  logic             s_axi_aclk,
    input  logic             s_axi_aresetn,
    input  logic             enable,
    input  logic [23:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tuser,
    input  logic             s_axis_tlast,
    output logic [6:0]       ser_data_0,
    output logic [6:0]       ser_data_1,
    output logic [6:0]       ser_data_2,
    output logic [6:0]       ser_data_3,
    output logic [6:0]       ser_clk,
    output logic             tx_active,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             sof_err,
    output logic             eol_err
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] gap_cnt, pix_cnt, line_cnt;
    logic             vld_p0;
    logic             pix_last, line_last, first_pix, gap_done;
    clink_word_t      word_p0;
    logic [6:0]       lane0_p0, lane1_p0, lane2_p0, lane3_p0;
    logic [6:0]       lane0_p1, lane1_p1, lane2_p1, lane3_p1;

    // A pixel is consumed only while a line is open and the source has one.
    assign s_axis_tready = (state == LINE_ON);
    assign vld_p0        = (state == LINE_ON) && s_axis_tvalid;
    assign tx_active     = (state != IDLE);
    assign ser_clk       = CLK_PATTERN;

    assign pix_last  = (pix_cnt == CNT_W'(H_ACTIVE - 1));
    assign line_last = (line_cnt == CNT_W'(V_ACTIVE - 1));
    assign first_pix = (pix_cnt == '0) && (line_cnt == '0);
    assign gap_done  = ((state == V_GAP) && (gap_cnt == CNT_W'(V_BLANK - 1))) ||
                       ((state == H_GAP) && (gap_cnt == CNT_W'(H_BLANK - 1)));

    // Assemble this clock's Camera Link word; pixel bits are zero unless consumed.
    always_comb begin
        word_p0      = '0;
        word_p0.fval = (state == LINE_ON) || (state == H_GAP);
        word_p0.lval = (state == LINE_ON);
        word_p0.dval = vld_p0;
        if (vld_p0) begin
            word_p0.a = s_axis_tdata[7:0];
            word_p0.b = s_axis_tdata[15:8];
            word_p0.c = s_axis_tdata[23:16];
        end
    end

    clink_slot_mapper u_slot_mapper (
        .word   (word_p0),
        .lane_0 (lane0_p0),
        .lane_1 (lane1_p0),
        .lane_2 (lane2_p0),
        .lane_3 (lane3_p0)
    );

    // State register.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame timing: enable is only sampled when leaving the vertical gap,
    // so a frame in flight always completes.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = V_GAP;
            V_GAP:   if (gap_done) state_nxt = enable ? LINE_ON : IDLE;
            LINE_ON: if (vld_p0 && pix_last) state_nxt = line_last ? V_GAP : H_GAP;
            H_GAP:   if (gap_done) state_nxt = LINE_ON;
            default: state_nxt = IDLE;
        endcase
    end

    // Blanking, pixel, line and frame counters plus sticky sideband errors.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            gap_cnt   <= '0;
            pix_cnt   <= '0;
            line_cnt  <= '0;
            frame_cnt <= '0;
            sof_err   <= 1'b0;
            eol_err   <= 1'b0;
        end else begin
            if (((state == V_GAP) || (state == H_GAP)) && !gap_done) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
            if (vld_p0) begin
                if (s_axis_tuser != first_pix) sof_err <= 1'b1;
                if (s_axis_tlast != pix_last)  eol_err <= 1'b1;
                if (pix_last) begin
                    pix_cnt <= '0;
                    if (line_last) begin
                        line_cnt  <= '0;
                        frame_cnt <= frame_cnt + 1'b1;
                    end else begin
                        line_cnt <= line_cnt + 1'b1;
                    end
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end
        end
    end

    // Output register: lane words leave one clock after they are formed.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            lane0_p1 <= '0;
            lane1_p1 <= '0;
            lane2_p1 <= '0;
            lane3_p1 <= '0;
        end else begin
            lane0_p1 <= lane0_p0;
            lane1_p1 <= lane1_p0;
            lane2_p1 <= lane2_p0;
            lane3_p1 <= lane3_p0;
        end
    end

    assign ser_data_0 = lane0_p1;
    assign ser_data_1 = lane1_p1;
    assign ser_data_2 = lane2_p1;
    assign ser_data_3 = lane3_p1;

endmodule
